// File: rtl/acq_gate_pkg.sv
// Shared definitions for the acquisition gate: one-hot FSM encoding and decimation field width.
package acq_gate_pkg;

  localparam int unsigned DecimW = 4;
  localparam int unsigned StW    = 4;

  localparam logic [StW-1:0] StIdle  = 4'b0001;
  localparam logic [StW-1:0] StDelay = 4'b0010;
  localparam logic [StW-1:0] StAcq   = 4'b0100;
  localparam logic [StW-1:0] StDone  = 4'b1000;

endpackage

// File: rtl/acq_gate_if.sv
// FIFO write-side bundle between the acquisition gate (master) and the sample FIFO (slave).
interface acq_gate_if #(
  parameter int unsigned DATA_W = 8
);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              fifo_full;

  modport master (
    output wr_en,
    output wr_data,
    input  fifo_full
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output fifo_full
  );

endinterface

// File: rtl/acq_slot_cnt.sv
// Slot timing: decimation spacing counter plus remaining-slot counter, loaded at trigger accept.
module acq_slot_cnt
  import acq_gate_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              run,
  input  logic              clear,
  input  logic [DecimW-1:0] decim,
  input  logic [CNT_W-1:0]  length,
  output logic              slot,
  output logic              last
);

  logic [DecimW-1:0] decim_q;
  logic [DecimW-1:0] dec_cnt_q;
  logic [CNT_W-1:0]  remain_q;

  assign slot = run && (remain_q != '0) && (dec_cnt_q == '0);
  // Zero remaining covers length=0: finish on the first ACQ cycle without a slot.
  assign last = run && ((remain_q == '0) || (slot && (remain_q == CNT_W'(1))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decim_q   <= '0;
      dec_cnt_q <= '0;
      remain_q  <= '0;
    end else if (clear) begin
      dec_cnt_q <= '0;
      remain_q  <= '0;
    end else if (load) begin
      decim_q   <= decim;
      dec_cnt_q <= '0;
      remain_q  <= length;
    end else if (run) begin
      if (slot) begin
        remain_q  <= remain_q - CNT_W'(1);
        dec_cnt_q <= decim_q;
      end else if (dec_cnt_q != '0) begin
        dec_cnt_q <= dec_cnt_q - DecimW'(1);
      end
    end
  end

endmodule

// File: rtl/acq_gate.sv
// Triggered acquisition gate: after a programmable delay, writes decimated ADC samples to a FIFO.
module acq_gate
  import acq_gate_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              i_clk100M,
  input  logic              i_rst_n,
  input  logic              i_trig_recv,
  input  logic              i_arm,
  input  logic              i_abort,
  input  logic [CNT_W-1:0]  i_start_delay,
  input  logic [CNT_W-1:0]  i_length,
  input  logic [DecimW-1:0] i_decim,
  input  logic [DATA_W-1:0] i_adc_data,
  acq_gate_if.master        fifo,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow,
  output logic              o_trig_miss
);

  logic [StW-1:0]    state_q, state_d;
  logic [CNT_W-1:0]  delay_q, delay_d;
  logic              trig_prev_q;
  logic              wr_en_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              overflow_q;
  logic              trig_miss_q;

  logic trig_edge;
  logic accept;
  logic in_acq;
  logic slot;
  logic slot_last;
  logic slot_fire;

  assign trig_edge = i_trig_recv && !trig_prev_q;
  assign accept    = (state_q == StIdle) && trig_edge && i_arm && !i_abort;
  assign in_acq    = (state_q == StAcq);
  assign slot_fire = slot && !i_abort;

  acq_slot_cnt #(
    .CNT_W(CNT_W)
  ) u_slot_cnt (
    .clk   (i_clk100M),
    .rst_n (i_rst_n),
    .load  (accept),
    .run   (in_acq),
    .clear (i_abort),
    .decim (i_decim),
    .length(i_length),
    .slot  (slot),
    .last  (slot_last)
  );

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          // Zero delay skips DELAY so the first ACQ cycle is the one after the edge.
          if (i_start_delay == '0) begin
            state_d = StAcq;
          end else begin
            state_d = StDelay;
            delay_d = i_start_delay;
          end
        end
      end
      StDelay: begin
        if (delay_q <= CNT_W'(1)) begin
          state_d = StAcq;
          delay_d = '0;
        end else begin
          delay_d = delay_q - CNT_W'(1);
        end
      end
      StAcq: begin
        if (slot_last) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (i_abort) begin
      state_d = StIdle;
      delay_d = '0;
    end
  end

  always_ff @(posedge i_clk100M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      delay_q     <= '0;
      trig_prev_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      overflow_q  <= 1'b0;
      trig_miss_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      delay_q     <= delay_d;
      trig_prev_q <= i_trig_recv;
      wr_en_q     <= slot_fire && !fifo.fifo_full;
      if (slot_fire) wr_data_q <= i_adc_data;
      if (accept) begin
        overflow_q  <= 1'b0;
        trig_miss_q <= 1'b0;
      end else begin
        if (slot_fire && fifo.fifo_full) overflow_q <= 1'b1;
        if (trig_edge && (state_q != StIdle)) trig_miss_q <= 1'b1;
      end
    end
  end

  assign fifo.wr_en   = wr_en_q;
  assign fifo.wr_data = wr_data_q;
  assign o_busy       = (state_q == StDelay) || (state_q == StAcq);
  assign o_done       = (state_q == StDone);
  assign o_overflow   = overflow_q;
  assign o_trig_miss  = trig_miss_q;

endmodule

// File: tb/tb_acq_gate.sv
// Self-checking bench for acq_gate: vector table of acquisitions plus abort/reset/arm sequences.
module tb_acq_gate;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          trig   = 1'b0;
  logic          arm    = 1'b0;
  logic          abort  = 1'b0;
  logic [CW-1:0] sdelay = '0;
  logic [CW-1:0] len    = '0;
  logic [3:0]    decim  = '0;
  logic [DW-1:0] adc    = '0;
  logic          busy, done, ovf, miss;

  acq_gate_if #(.DATA_W(DW)) fifo_if ();

  acq_gate #(
    .DATA_W(DW),
    .CNT_W (CW)
  ) dut (
    .i_clk100M    (clk),
    .i_rst_n      (rst_n),
    .i_trig_recv  (trig),
    .i_arm        (arm),
    .i_abort      (abort),
    .i_start_delay(sdelay),
    .i_length     (len),
    .i_decim      (decim),
    .i_adc_data   (adc),
    .fifo         (fifo_if),
    .o_busy       (busy),
    .o_done       (done),
    .o_overflow   (ovf),
    .o_trig_miss  (miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int data;
  } wr_t;

  typedef struct {
    int d;
    int l;
    int m;
    int mask;
    int miss_at;
    int exp_w;
    int exp_ovf;
    int exp_miss;
  } vec_t;

  wr_t  sb[$];
  wr_t  e_w;
  vec_t vecs[7];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   wr_total = 0;
  int   done_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Inputs change #1 after each rising edge; adc ramps with the cycle number.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    adc = DW'(cyc);
  endtask

  always @(negedge clk) begin
    if (done) done_total++;
    if (fifo_if.wr_en) begin
      wr_total++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got data 0x%0h at cycle %0d, required no write",
                 fifo_if.wr_data, cyc);
      end else begin
        e_w = sb.pop_front();
        chk("wr_cycle", cyc, e_w.cyc);
        chk("wr_data", 32'(fifo_if.wr_data), e_w.data);
      end
    end
  end

  task automatic run_acq(input int idx, input vec_t v);
    int  e, s, exp_done, done_cyc, base_w;
    bit  seen;
    base_w = wr_total;
    sdelay = CW'(v.d);
    len    = CW'(v.l);
    decim  = 4'(v.m);
    arm    = 1'b1;
    trig   = 1'b1;
    e      = cyc;
    for (int k = 0; k < v.l; k++) begin
      s = e + v.d + 1 + k * (v.m + 1);
      if (((v.mask >> k) & 1) == 0) sb.push_back('{s + 1, s & 255});
    end
    exp_done = e + v.d + 2 + ((v.l == 0) ? 0 : (v.l - 1) * (v.m + 1));
    tick();
    trig   = 1'b0;
    sdelay = CW'($urandom);
    len    = CW'($urandom);
    decim  = 4'($urandom);
    chk($sformatf("v%0d_busy_start", idx), 32'(busy), 1);
    chk($sformatf("v%0d_miss_cleared", idx), 32'(miss), 0);
    chk($sformatf("v%0d_ovf_cleared", idx), 32'(ovf), 0);
    seen = 1'b0;
    done_cyc = -1;
    for (int n = 0; n < 400 && !seen; n++) begin
      fifo_if.fifo_full = 1'b0;
      for (int k = 0; k < v.l && k < 32; k++) begin
        if ((cyc == e + v.d + 1 + k * (v.m + 1)) && (((v.mask >> k) & 1) == 1))
          fifo_if.fifo_full = 1'b1;
      end
      trig = (v.miss_at > 0) && (cyc == e + v.miss_at);
      if (done) begin
        seen = 1'b1;
        done_cyc = cyc;
      end else begin
        tick();
      end
    end
    fifo_if.fifo_full = 1'b0;
    trig = 1'b0;
    chk($sformatf("v%0d_done_cycle", idx), done_cyc - e, exp_done - e);
    tick();
    chk($sformatf("v%0d_done_one_cycle", idx), 32'(done), 0);
    chk($sformatf("v%0d_idle_after", idx), 32'(busy), 0);
    tick();
    chk($sformatf("v%0d_writes", idx), wr_total - base_w, v.exp_w);
    chk($sformatf("v%0d_sb_empty", idx), sb.size(), 0);
    chk($sformatf("v%0d_overflow", idx), 32'(ovf), v.exp_ovf);
    chk($sformatf("v%0d_trig_miss", idx), 32'(miss), v.exp_miss);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1);
  end

  initial begin
    int base_w, base_d;
    fifo_if.fifo_full = 1'b0;
    //          d  l   m   mask      miss w  ovf miss
    vecs[0] = '{5, 4,  0,  0,        0,   4, 0,  0};
    vecs[1] = '{0, 3,  2,  0,        0,   3, 0,  0};
    vecs[2] = '{2, 4,  0,  'b0010,   0,   3, 1,  0};
    vecs[3] = '{0, 0,  0,  0,        0,   0, 0,  0};
    vecs[4] = '{0, 6,  1,  0,        4,   6, 0,  1};
    vecs[5] = '{1, 2,  15, 0,        0,   2, 0,  0};
    vecs[6] = '{3, 5,  1,  'b10001,  0,   3, 1,  0};

    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_miss", 32'(miss), 0);
    chk("rst_wr_en", 32'(fifo_if.wr_en), 0);
    chk("rst_wr_data", 32'(fifo_if.wr_data), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 7; i++) run_acq(i, vecs[i]);

    // Abort wins over a simultaneous armed trigger in IDLE.
    arm = 1'b1; trig = 1'b1; abort = 1'b1;
    tick();
    trig = 1'b0; abort = 1'b0;
    chk("abort_prio_busy", 32'(busy), 0);
    repeat (3) tick();

    // Abort while in DELAY.
    base_w = wr_total; base_d = done_total;
    sdelay = 10; len = 4; decim = 0; trig = 1'b1;
    tick();
    trig = 1'b0;
    chk("abort_delay_busy_before", 32'(busy), 1);
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_delay_idle", 32'(busy), 0);
    repeat (30) tick();
    chk("abort_delay_no_writes", wr_total - base_w, 0);
    chk("abort_delay_no_done", done_total - base_d, 0);

    // Reset asserted mid-ACQ: two writes land first, then nothing.
    base_w = wr_total; base_d = done_total;
    sdelay = 0; len = 10; decim = 0; trig = 1'b1;
    sb.push_back('{cyc + 2, (cyc + 1) & 255});
    sb.push_back('{cyc + 3, (cyc + 2) & 255});
    tick();
    trig = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_acq_wr_en", 32'(fifo_if.wr_en), 0);
    chk("rst_acq_busy", 32'(busy), 0);
    chk("rst_acq_wr_data", 32'(fifo_if.wr_data), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    chk("rst_acq_writes", wr_total - base_w, 2);
    chk("rst_acq_no_done", done_total - base_d, 0);
    chk("rst_acq_sb_empty", sb.size(), 0);

    // Disarmed trigger is ignored.
    base_w = wr_total; base_d = done_total;
    arm = 1'b0; sdelay = 0; len = 3; trig = 1'b1;
    tick();
    trig = 1'b0;
    chk("disarm_busy", 32'(busy), 0);
    repeat (20) tick();
    chk("disarm_no_writes", wr_total - base_w, 0);
    chk("disarm_no_done", done_total - base_d, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
